// File: rtl/frame_link_pkg.sv
// Shared types and defaults for the slow frame link receive path.
package frame_link_pkg;

    localparam int unsigned FRAME_LEN_DEF  = 2048;
    localparam int unsigned DATA_WIDTH_DEF = 13;
    localparam int unsigned CHECKSUM_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FIRST = 3'd1,
        RECV       = 3'd2,
        DONE       = 3'd3,
        ERR        = 3'd4
    } rx_state_t;

endpackage

// File: rtl/frame_rx_sync.sv
// Strobe synchroniser, rising-edge detector and matching data delay line.
// strobe_edge and word are registered together, so the word presented with a
// one-cycle strobe_edge pulse is the word that was on the link at the strobe.
module frame_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_WIDTH  = 13
) (
    input  logic                  adc_clk_out,
    input  logic                  reset,
    input  logic                  tx_ok_in,
    input  logic [DATA_WIDTH-1:0] frame_in,
    output logic                  strobe_edge,
    output logic [DATA_WIDTH-1:0] word
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic [DATA_WIDTH-1:0]  dly [SYNC_STAGES];

    // Synchronise the strobe, keep one history bit, and delay data by the same depth
    always_ff @(posedge adc_clk_out or negedge reset) begin
        if (!reset) begin
            sync        <= '0;
            hist        <= 1'b0;
            strobe_edge <= 1'b0;
            word        <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                dly[i] <= '0;
            end
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], tx_ok_in};
            hist        <= sync[SYNC_STAGES-1];
            strobe_edge <= sync[SYNC_STAGES-1] & ~hist;
            dly[0]      <= frame_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                dly[i] <= dly[i-1];
            end
            word        <= dly[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/frame_receiver.sv
// Frame receiver: captures FRAME_LEN link words into RAM and serves a read port.
// Optional running checksum of stored words is built when FRAME_RX_CHECKSUM_EN
// is defined; otherwise checksum is tied to zero.
module frame_receiver
    import frame_link_pkg::*;
#(
    parameter int unsigned FRAME_LEN     = FRAME_LEN_DEF,
    parameter int unsigned ADDR_WIDTH    = 11,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned TIMEOUT_WIDTH = 20
) (
    input  logic                      adc_clk_out,
    input  logic                      reset,
    input  logic                      tx_ok_in,
    input  logic [DATA_WIDTH-1:0]     frame_in,
    input  logic                      arm,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      timeout_err,
    output logic [ADDR_WIDTH:0]       wr_count,
    output logic [CHECKSUM_WIDTH-1:0] checksum
);

    localparam int unsigned      CNT_W      = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FRAME_LEN);

    localparam logic [2:0] S_IDLE       = 3'(IDLE);
    localparam logic [2:0] S_WAIT_FIRST = 3'(WAIT_FIRST);
    localparam logic [2:0] S_RECV       = 3'(RECV);
    localparam logic [2:0] S_DONE       = 3'(DONE);
    localparam logic [2:0] S_ERR        = 3'(ERR);

    logic [2:0]               state;
    logic [2:0]               state_nxt;
    logic [CNT_W-1:0]         wr_count_nxt;
    logic [TIMEOUT_WIDTH-1:0] gap;
    logic [TIMEOUT_WIDTH-1:0] gap_nxt;
    logic                     frame_done_nxt;
    logic                     timeout_err_nxt;
    logic                     busy_nxt;
    logic                     arm_ok_c;
    logic                     wr_en_c;
    logic [ADDR_WIDTH-1:0]    wr_addr_c;
    logic                     rd_ok_c;
    logic                     strobe_edge;
    logic [DATA_WIDTH-1:0]    word;
    logic [DATA_WIDTH-1:0]    mem [FRAME_LEN];

    frame_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_sync (
        .adc_clk_out (adc_clk_out),
        .reset       (reset),
        .tx_ok_in    (tx_ok_in),
        .frame_in    (frame_in),
        .strobe_edge (strobe_edge),
        .word        (word)
    );

    // arm only counts when no capture is in progress; it outranks a coincident edge
    assign arm_ok_c = arm & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
    assign rd_ok_c  = rd_en & (state == S_DONE);

    // Next-state, write control and next values of the registered status outputs
    always_comb begin
        state_nxt       = state;
        wr_count_nxt    = wr_count;
        gap_nxt         = gap;
        frame_done_nxt  = frame_done;
        timeout_err_nxt = timeout_err;
        wr_en_c         = 1'b0;
        wr_addr_c       = wr_count[ADDR_WIDTH-1:0];
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (arm_ok_c) begin
                    state_nxt       = S_WAIT_FIRST;
                    wr_count_nxt    = '0;
                    gap_nxt         = '0;
                    frame_done_nxt  = 1'b0;
                    timeout_err_nxt = 1'b0;
                end
            end
            S_WAIT_FIRST: begin
                if (strobe_edge) begin
                    wr_en_c      = 1'b1;
                    wr_addr_c    = '0;
                    wr_count_nxt = CNT_W'(1);
                    gap_nxt      = '0;
                    state_nxt    = S_RECV;
                end
            end
            S_RECV: begin
                // An edge always wins over a simultaneous gap saturation
                if (strobe_edge) begin
                    wr_en_c      = 1'b1;
                    wr_count_nxt = wr_count + CNT_W'(1);
                    gap_nxt      = '0;
                    if (wr_count_nxt == FULL_COUNT) begin
                        state_nxt      = S_DONE;
                        frame_done_nxt = 1'b1;
                    end
                end else begin
                    gap_nxt = gap + TIMEOUT_WIDTH'(1);
                    if (gap_nxt == '1) begin
                        state_nxt       = S_ERR;
                        timeout_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt = (state_nxt == S_WAIT_FIRST) | (state_nxt == S_RECV);
    end

    // State and status registers
    always_ff @(posedge adc_clk_out or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wr_count    <= '0;
            gap         <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_count    <= wr_count_nxt;
            gap         <= gap_nxt;
            frame_done  <= frame_done_nxt;
            timeout_err <= timeout_err_nxt;
            busy        <= busy_nxt;
        end
    end

    // Frame storage; contents survive reset
    always_ff @(posedge adc_clk_out) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= word;
        end
    end

    // Registered read port, only serviced while a complete frame is held
    always_ff @(posedge adc_clk_out or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok_c;
            if (rd_ok_c) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

`ifdef FRAME_RX_CHECKSUM_EN
    // Wrap-around sum of stored words, tracking the RAM writes
    always_ff @(posedge adc_clk_out or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (arm_ok_c) begin
            checksum <= '0;
        end else if (wr_en_c) begin
            checksum <= checksum + CHECKSUM_WIDTH'(word);
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// Self-checking bench for frame_receiver: table-driven reads with a scoreboard.
module tb_frame_receiver;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 13;
    localparam int unsigned FL = 2048;
    localparam int unsigned TW = 10;

    logic          adc_clk_out = 1'b0;
    logic          reset       = 1'b0;
    logic          tx_ok_in    = 1'b0;
    logic [DW-1:0] frame_in    = '0;
    logic          arm         = 1'b0;
    logic          rd_en       = 1'b0;
    logic [AW-1:0] rd_addr     = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;
    logic [AW:0]   wr_count;
    logic [15:0]   checksum;

    frame_receiver #(
        .FRAME_LEN     (FL),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .SYNC_STAGES   (2),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .adc_clk_out (adc_clk_out),
        .reset       (reset),
        .tx_ok_in    (tx_ok_in),
        .frame_in    (frame_in),
        .arm         (arm),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .wr_count    (wr_count),
        .checksum    (checksum)
    );

    always #5 adc_clk_out = ~adc_clk_out;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_vec_t;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    logic [15:0]   model_sum;
    rd_vec_t       vec[6];
    int            addrs[6] = '{5, 0, 1, 500, 1024, 2047};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef FRAME_RX_CHECKSUM_EN
        return s;
`else
        return 16'h0000 & s;
`endif
    endfunction

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 5 + 3);
    endfunction

    task automatic tick();
        @(posedge adc_clk_out);
        #1;
    endtask

    // One link word: strobe high 4 cycles, low 2; optional arm aligned with the detected edge
    task automatic send_word(input logic [DW-1:0] w, input logic arm_on_edge);
        frame_in = w;
        tx_ok_in = 1'b1;
        tick(); tick(); tick();
        if (arm_on_edge) arm = 1'b1;
        tick();
        arm      = 1'b0;
        tx_ok_in = 1'b0;
        tick(); tick();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input logic expect_valid);
        rd_addr = a;
        rd_en   = 1'b1;
        if (expect_valid) exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
        check("rd_valid_latency", 32'(rd_valid), 32'(expect_valid));
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 6; i++) do_read(vec[i].addr, vec[i].exp, 1'b1);
        tick();
        check("rd_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every valid read must match the oldest outstanding expectation
    always @(negedge adc_clk_out) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
            else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        reset = 1'b1;
        tick();

        // Strobes before any arm are ignored
        for (int i = 0; i < 10; i++) send_word(DW'(13'h1AAA ^ i), 1'b0);
        check("prearm_busy", 32'(busy), 32'd0);
        check("prearm_wr_count", 32'(wr_count), 32'd0);

        // Ramp frame with a stray arm mid-capture
        pulse_arm();
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_wr_count", 32'(wr_count), 32'd0);
        model_sum = '0;
        for (int i = 0; i < int'(FL); i++) begin
            if (i == 500) pulse_arm();
            if (i == int'(FL) - 1) check("pre_last_done", 32'(frame_done), 32'd0);
            send_word(DW'(i), 1'b0);
            model_sum = model_sum + 16'(i);
            if (i == 0) check("first_wr_count", 32'(wr_count), 32'd1);
            if (i == 500) check("midarm_wr_count", 32'(wr_count), 32'd501);
        end
        check("ramp_done", 32'(frame_done), 32'd1);
        check("ramp_wr_count", 32'(wr_count), 32'(FL));
        check("ramp_busy", 32'(busy), 32'd0);
        check("ramp_timeout", 32'(timeout_err), 32'd0);
        check("ramp_checksum", 32'(checksum), 32'(exp_sum(16'hFC00)));
        check("ramp_model_sum", 32'(checksum), 32'(exp_sum(model_sum)));
        for (int i = 0; i < 6; i++) vec[i] = '{addr: AW'(addrs[i]), exp: DW'(addrs[i])};
        run_table();
        check("read_keeps_done", 32'(frame_done), 32'd1);

        // arm and an edge together in DONE: arm wins, that word is dropped
        send_word(DW'(13'h1555), 1'b1);
        check("armedge_busy", 32'(busy), 32'd1);
        check("armedge_wr_count", 32'(wr_count), 32'd0);
        check("armedge_done", 32'(frame_done), 32'd0);
        check("armedge_checksum", 32'(checksum), 32'd0);
        model_sum = '0;
        for (int i = 0; i < int'(FL); i++) begin
            send_word(pat(i), 1'b0);
            model_sum = model_sum + 16'(pat(i));
        end
        check("pat_done", 32'(frame_done), 32'd1);
        check("pat_wr_count", 32'(wr_count), 32'(FL));
        check("pat_checksum", 32'(checksum), 32'(exp_sum(model_sum)));
        for (int i = 0; i < 6; i++) vec[i] = '{addr: AW'(addrs[i]), exp: pat(addrs[i])};
        run_table();

        // Gap timeout after 100 words
        pulse_arm();
        model_sum = '0;
        for (int i = 0; i < 100; i++) begin
            send_word(DW'(100 + i), 1'b0);
            model_sum = model_sum + 16'(100 + i);
        end
        waited = 0;
        while (timeout_err !== 1'b1 && waited < 3000) begin
            tick();
            waited++;
        end
        check("timeout_seen", 32'(timeout_err), 32'd1);
        check("timeout_not_early", 32'(waited >= 1000), 32'd1);
        check("timeout_wr_count", 32'(wr_count), 32'd100);
        check("timeout_done", 32'(frame_done), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_checksum", 32'(checksum), 32'(exp_sum(model_sum)));
        do_read(AW'(5), '0, 1'b0);

        // Reset in the middle of a capture
        pulse_arm();
        for (int i = 0; i < 1000; i++) send_word(DW'(i), 1'b0);
        check("mid_busy_before", 32'(busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wr_count", 32'(wr_count), 32'd0);
        check("midrst_done", 32'(frame_done), 32'd0);
        check("midrst_timeout", 32'(timeout_err), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        check("midrst_checksum", 32'(checksum), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        do_read(AW'(5), '0, 1'b0);
        check("idle_busy", 32'(busy), 32'd0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_receiver.md
Name: frame_receiver

Overview:
- Receiving end of the slow frame link that carries captured ADC frames (DATA_WIDTH-bit word bus plus a tx_ok level strobe; one word per strobe rising edge).
- Synchronises the strobe into the adc_clk_out domain and detects its rising edge.
- Writes FRAME_LEN words into an internal RAM, then exposes the stored frame through a registered read port.
- Sits at the far end of the link, feeding downstream processing or host readout.

Parameters:
- FRAME_LEN, 2048: words per frame; a power of two.
- ADDR_WIDTH, 11: log2(FRAME_LEN).
- DATA_WIDTH, 13: width of the word bus.
- SYNC_STAGES, 2: synchroniser flops on tx_ok_in; minimum 2.
- TIMEOUT_WIDTH, 20: width of the inter-strobe gap counter; a gap of 2^TIMEOUT_WIDTH-1 cycles aborts the frame.

Ports:
- adc_clk_out  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low.
- tx_ok_in  in  1  link strobe, asynchronous; each rising edge marks one word.
- frame_in  in  DATA_WIDTH  link data; stable around the strobe edge.
- arm  in  1  one-cycle pulse that starts a new capture.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data valid, one cycle after an accepted rd_en.
- busy  out  1  high in WAIT_FIRST and RECV.
- frame_done  out  1  level; a complete frame is stored.
- timeout_err  out  1  level; the frame was aborted on a gap timeout.
- wr_count  out  ADDR_WIDTH+1  number of words written in the current frame.
- checksum  out  16  see Optional Feature.

Behaviour:
Reset:
- All outputs 0; state IDLE; gap counter 0; synchroniser flops 0.
- RAM contents are not cleared.

Input path:
- tx_ok_in passes through SYNC_STAGES flops plus one history flop.
- edge = sync_out & ~hist.
- frame_in is delayed by SYNC_STAGES flops so the captured word is the one aligned with the strobe edge.
- The link holds a word for many cycles, so no further alignment is needed.

FSM states: IDLE, WAIT_FIRST, RECV, DONE, ERR.
- IDLE/DONE/ERR + arm -> WAIT_FIRST. Clears wr_count, frame_done, timeout_err, checksum and the gap counter.
- WAIT_FIRST + edge -> RECV. Writes RAM[0]; wr_count=1. No timeout in this state.
- RECV + edge:
  - Writes RAM[wr_count[ADDR_WIDTH-1:0]]; wr_count+1; gap counter cleared.
  - If the new wr_count == FRAME_LEN -> DONE, with frame_done=1 in the same cycle the state registers DONE.
- RECV, no edge: gap counter +1. When it saturates at all-ones -> ERR with timeout_err=1; wr_count holds the partial count.

Boundary rules:
- arm in WAIT_FIRST/RECV: ignored.
- edge in IDLE/DONE/ERR: ignored; RAM is not written.
- arm and edge in the same cycle in IDLE/DONE/ERR: arm wins; that edge is not written.
- The last edge of a frame and the gap-counter saturation in the same cycle: the edge wins and the FSM goes to DONE.
- wr_count never exceeds FRAME_LEN; there is no address wrap within a frame.

Read port:
- rd_en accepted only in DONE.
- rd_data <= RAM[rd_addr] and rd_valid=1 on the following cycle.
- rd_en in any other state: rd_valid=0 and rd_data holds its previous value.
- Reading does not change the state.

Reset mid-operation: returns to IDLE immediately; any partial frame is discarded logically.

Optional Feature:
- Macro: FRAME_RX_CHECKSUM_EN.
- Defined:
  - checksum = 16-bit wrap-around sum of every word written in the current frame, zero-extended.
  - Updated in the same cycle as the RAM write; cleared on arm and on reset.
  - Valid when frame_done=1.
- Undefined: checksum is tied to 0 and no adder is built.

Decomposition:
- Package frame_link_pkg:
  - state enum rx_state_t {IDLE, WAIT_FIRST, RECV, DONE, ERR};
  - FRAME_LEN_DEF=2048, DATA_WIDTH_DEF=13, CHECKSUM_WIDTH=16.
- Sub-module frame_rx_sync: strobe synchroniser, edge detect and the aligned data delay line; outputs edge and word.

Test Plan:
- Arm, then 2048 strobes carrying ramp words 0..2047 -> frame_done=1 after the 2048th edge; wr_count=2048; reading addr 5 gives rd_data=5 with rd_valid one cycle later; with the macro, checksum=0xFC00.
- Arm, 100 strobes, then no strobe for 2^20 cycles -> timeout_err=1, state ERR, wr_count=100, frame_done=0.
- Ten strobe edges before any arm -> RAM untouched, busy=0; a later arm plus 2048 edges produces a normal frame starting at RAM[0].
- arm pulsed at word 500 of a capture -> ignored; the capture completes at 2048 and the words are unchanged.
- Reset asserted at word 1000 -> all outputs 0, state IDLE; a read in IDLE gives rd_valid=0.
- arm and a strobe edge in the same cycle in DONE -> WAIT_FIRST; that edge is not stored; the next edge writes addr 0.
